// File: rtl/request_encoder_pkg.sv
// Shared constants and state type for the request encoder.
// Also hosts the 8-line lowest-set-bit helper.
package request_encoder_pkg;

  localparam int N_LINES = 32;
  localparam int IDX_W   = 5;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } enc_state_t;

  // Lowest set bit of an 8-line group; 0 when empty.
  function automatic logic [2:0] pe8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/request_encoder_32_to_5_penc.sv
// Lowest-first 32-to-5 priority encoder.
// Four 8-to-3 stages feed a 4-to-2 group select.
module priority_encoder_32_to_5
  import request_encoder_pkg::*;
(
  input  logic [31:0] in,
  output logic [4:0]  idx,
  output logic        any
);

  logic [3:0] g_any;
  logic [2:0] g_lo [4];
  logic [1:0] grp;

  // Per-group presence and local lowest index.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      g_any[g] = |in[g*8 +: 8];
      g_lo[g]  = pe8(in[g*8 +: 8]);
    end
  end

  // Pick the lowest non-empty group.
  always_comb begin
    grp = 2'd0;
    if (g_any[0])      grp = 2'd0;
    else if (g_any[1]) grp = 2'd1;
    else if (g_any[2]) grp = 2'd2;
    else if (g_any[3]) grp = 2'd3;
  end

  assign any = |g_any;
  assign idx = {grp, g_lo[grp]};

endmodule

// File: rtl/request_encoder_32_to_5.sv
// Sequential request encoder: accepts a 32-bit vector,
// then emits each set bit index, lowest first, one per beat.
module request_encoder_32_to_5
  import request_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_bits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        busy
);

  enc_state_t  state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  pe_idx;
  logic        pe_any;
  logic        in_drain;
  logic        single;

  priority_encoder_32_to_5 u_penc (
    .in  (pending_q),
    .idx (pe_idx),
    .any (pe_any)
  );

  assign in_drain  = (state_q == S_DRAIN);
  assign single    = pe_any &
                     ((pending_q & (pending_q - 32'd1)) == 32'd0);
  assign req_ready = ~rst & ena & ~in_drain;
  assign out_valid = ~rst & ena & in_drain;
  assign busy      = ~rst & in_drain;
  assign out_index = out_valid ? pe_idx : 5'd0;
  assign out_last  = out_valid & single;

  // Next state: load on non-empty accept, clear served bit on transfer.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (req_valid & req_ready & (|req_bits)) begin
      pending_d = req_bits;
      state_d   = S_DRAIN;
    end
    if (out_valid & out_ready) begin
      pending_d = pending_q & ~(32'd1 << pe_idx);
      if (single) state_d = S_IDLE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_request_encoder_32_to_5.sv
// Randomized self-checking bench for request_encoder_32_to_5.
// Reference model: queue of set-bit positions per vector.
module tb_request_encoder_32_to_5;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic        req_valid, req_ready;
  logic [31:0] req_bits;
  logic        out_valid, out_ready, out_last, busy;
  logic [4:0]  out_index;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  request_encoder_32_to_5 dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bits  (req_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector, then drain it with random stalls / ena drops.
  task automatic run_vec(input logic [31:0] v,
                         input int stall_pct,
                         input int ena_pct);
    int q[$];
    int budget;
    for (int i = 0; i < 32; i++)
      if (v[i]) q.push_back(i);
    ena       = 1'b1;
    req_valid = 1'b1;
    req_bits  = v;
    out_ready = 1'(($urandom_range(1)));
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_index", 32'(out_index), 32'd0);
    chk("idle_busy",  32'(busy),      32'd0);
    tick();
    req_valid = 1'b0;
    req_bits  = $urandom;
    budget    = 0;
    while (q.size() > 0 && budget < 400) begin
      ena       = ($urandom_range(99) >= 32'(ena_pct));
      out_ready = ($urandom_range(99) >= 32'(stall_pct));
      req_valid = 1'(($urandom_range(1)));
      req_bits  = $urandom;
      #1;
      chk("busy",      32'(busy),      32'd1);
      chk("req_ready", 32'(req_ready), 32'd0);
      chk("out_valid", 32'(out_valid), 32'(ena));
      chk("out_index", 32'(out_index), ena ? 32'(q[0]) : 32'd0);
      chk("out_last",  32'(out_last),
          32'(ena && q.size() == 1));
      if (ena && out_ready) void'(q.pop_front());
      tick();
      budget++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
    ena       = 1'b1;
    req_valid = 1'b0;
    out_ready = 1'(($urandom_range(1)));
    #1;
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_busy",  32'(busy),      32'd0);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_index", 32'(out_index), 32'd0);
    chk("post_last",  32'(out_last),  32'd0);
  endtask

  initial begin
    logic [31:0] v;
    rst       = 1'b1;
    ena       = 1'b1;
    req_valid = 1'b0;
    req_bits  = 32'd0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);

    // Directed vectors.
    run_vec(32'h0000_0001, 0, 0);
    run_vec(32'h8000_0011, 0, 0);
    run_vec(32'h0000_0030, 70, 0);
    run_vec(32'h0000_0000, 0, 0);
    run_vec(32'hFFFF_FFFF, 0, 0);
    run_vec(32'h0000_0104, 20, 40);
    run_vec(32'h8000_0000, 50, 30);

    // ena low in IDLE blocks accept.
    ena       = 1'b0;
    req_valid = 1'b1;
    req_bits  = 32'h0000_0005;
    #1;
    chk("ena0_ready", 32'(req_ready), 32'd0);
    tick();
    ena       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("ena0_busy",  32'(busy),      32'd0);
    chk("ena0_rdy2",  32'(req_ready), 32'd1);

    // Reset mid-drain discards the vector.
    req_valid = 1'b1;
    req_bits  = 32'hF000_0000;
    out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
    chk("rd_idx28", 32'(out_index), 32'd28);
    chk("rd_valid", 32'(out_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rd_valid0", 32'(out_valid), 32'd0);
    chk("rd_busy0",  32'(busy),      32'd0);
    chk("rd_ready",  32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_nobeat", 32'(out_valid), 32'd0);
    end

    // Random vectors, sparse and dense.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3))
        0:       v = $urandom;
        1:       v = $urandom & $urandom & $urandom;
        2:       v = 32'd1 << $urandom_range(31);
        default: v = $urandom & $urandom;
      endcase
      run_vec(v, 30, 15);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
